// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: default sizes, complex sample type, read FSM
// states and the index bit-reversal helper used by the SDF stages and reorder tail.
package fft_pkg;

    localparam int FFT_DW    = 24;
    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int BR_MAX    = 16;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Reverse the low 'bits' bits of k; 'bits' must be a constant at elaboration.
    function automatic logic [BR_MAX-1:0] bitrev(input logic [BR_MAX-1:0] k, input int bits);
        logic [BR_MAX-1:0] r;
        r = '0;
        for (int j = 0; j < BR_MAX; j++) begin
            r[BR_MAX-1-j] = k[j];
        end
        return r >> (BR_MAX - bits);
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One reorder bank: N words of {re,im}, synchronous write, combinational read.
module fft_reorder_bank #(
    parameter int N     = 8,
    parameter int LOG2N = 3,
    parameter int WW    = 48
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [LOG2N-1:0] waddr_i,
    input  logic [WW-1:0]    wdata_i,
    input  logic [LOG2N-1:0] raddr_i,
    output logic [WW-1:0]    rdata_o
);

    logic [WW-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// FFT output reorder: bit-reversed input stream is written into ping-pong banks
// and each completed frame is read out in natural order at one sample per cycle.
module fft_bitrev_reorder #(
    parameter int N     = fft_pkg::FFT_N,
    parameter int LOG2N = fft_pkg::FFT_LOG2N,
    parameter int DW    = fft_pkg::FFT_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
    output logic signed [DW-1:0] dout_r,
    output logic signed [DW-1:0] dout_i,
    output logic                 out_valid,
    output logic                 out_last
);
    import fft_pkg::*;

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic [1:0]       full_q, full_d, full_set, full_clr;
    logic [LOG2N-1:0] rcnt_q;
    logic             rbank_q;
    rd_state_e        state_q;

    logic             wr_last, rd_active, rd_last, other_ready;
    logic [LOG2N-1:0] wr_addr;
    logic [2*DW-1:0]  wr_word, rd_word0, rd_word1, rd_word;

    assign wr_last  = in_valid && (wcnt_q == CNT_LAST);
    assign wr_addr  = LOG2N'(bitrev(BR_MAX'(wcnt_q), LOG2N));
    assign wr_word  = {din_r, din_i};
    assign full_set = wr_last ? (2'b01 << wbank_q) : 2'b00;

    // rcnt_q is always 0 while idle, so an idle reader can emit index 0 directly.
    assign rd_active   = (state_q == RD_READ) || full_q[rbank_q];
    assign rd_last     = rd_active && (rcnt_q == CNT_LAST);
    assign full_clr    = rd_last ? (2'b01 << rbank_q) : 2'b00;
    assign other_ready = full_q[~rbank_q] || full_set[~rbank_q];
    assign rd_word     = rbank_q ? rd_word1 : rd_word0;

    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        full_d  = (full_q & ~full_clr) | full_set;
        if (in_valid) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wr_last) begin
                wbank_d = ~wbank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
            full_q  <= 2'b00;
        end else begin
            wcnt_q  <= wcnt_d;
            wbank_q <= wbank_d;
            full_q  <= full_d;
        end
    end

    fft_reorder_bank #(.N(N), .LOG2N(LOG2N), .WW(2*DW)) u_bank0 (
        .clk     (clk),
        .we_i    (in_valid && !wbank_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_word),
        .raddr_i (rcnt_q),
        .rdata_o (rd_word0)
    );

    fft_reorder_bank #(.N(N), .LOG2N(LOG2N), .WW(2*DW)) u_bank1 (
        .clk     (clk),
        .we_i    (in_valid && wbank_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_word),
        .raddr_i (rcnt_q),
        .rdata_o (rd_word1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            rcnt_q    <= '0;
            rbank_q   <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (rd_active) begin
                dout_r    <= rd_word[2*DW-1:DW];
                dout_i    <= rd_word[DW-1:0];
                out_valid <= 1'b1;
                out_last  <= rd_last;
                rcnt_q    <= rcnt_q + 1'b1;
                state_q   <= RD_READ;
                // A bank completing this very cycle counts, so frames chain with no bubble.
                if (rd_last) begin
                    rbank_q <= ~rbank_q;
                    if (!other_ready) begin
                        state_q <= RD_IDLE;
                    end
                end
            end
        end
    end

    wr_into_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && full_q[wbank_q]));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the bit-reverse reorder stage at N=8 with a queue scoreboard.
module tb_fft_bitrev_reorder;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int DW    = 24;
    localparam int W     = 2*DW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] din_r = '0;
    logic signed [DW-1:0] din_i = '0;
    logic signed [DW-1:0] dout_r, dout_i;
    logic                 out_valid, out_last;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int vcnt     = 0;
    int runs     = 0;
    logic prev_valid = 1'b0;

    // input slot j carries natural index br_seq[j] (hand-reversed for 3 bits)
    int br_seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .dout_r    (dout_r),
        .dout_i    (dout_i),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'({out_last, dout_r, dout_i}), 64'h1_0000_0000_0000 << 4);
            end else begin
                check("sample", 64'({out_last, dout_r, dout_i}), 64'(exp_q.pop_front()));
            end
        end
        if (out_valid && !prev_valid) runs++;
        if (out_valid) vcnt++;
        prev_valid = out_valid;
    end

    task automatic push_expected(input int base, input bit extreme);
        logic [DW-1:0] re, im;
        for (int k = 0; k < N; k++) begin
            re = DW'(k + base);
            im = DW'(-(k + base));
            if (extreme && k == 3) begin
                re = 24'h7FFFFF;
                im = 24'h800000;
            end
            exp_q.push_back({k == 7, re, im});
        end
    endtask

    // driver: slots first..first+count-1 of a frame, inputs change 1 after the edge
    task automatic drive_samples(input int base, input int first, input int count,
                                 input bit gapped, input bit extreme);
        for (int j = first; j < first + count; j++) begin
            in_valid = 1'b1;
            din_r = DW'(br_seq[j] + base);
            din_i = DW'(-(br_seq[j] + base));
            if (extreme && j == 6) begin
                din_r = 24'h7FFFFF;
                din_i = 24'h800000;
            end
            if (j == N - 1) push_expected(base, extreme);
            @(posedge clk); #1;
            if (gapped && j != N - 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string name);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check(name, 64'({out_valid, out_last, dout_r, dout_i}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_latency(input string name);
        @(posedge clk); #1;
        check(name, 64'({out_valid, dout_r}), 64'({1'b1, 24'd0}));
    endtask

    initial begin
        // reset
        #2;
        apply_reset("reset_state");

        // 1: single frame
        drive_samples(0, 0, 8, 1'b0, 1'b0);
        check_latency("t1_latency");
        wait_drain("t1_drain");

        // 2: three back-to-back frames, one contiguous 24-cycle run
        vcnt = 0; runs = 0;
        drive_samples(0, 0, 8, 1'b0, 1'b0);
        drive_samples(100, 0, 8, 1'b0, 1'b0);
        drive_samples(200, 0, 8, 1'b0, 1'b0);
        wait_drain("t2_drain");
        check("t2_valid_cycles", 64'(vcnt), 64'd24);
        check("t2_runs", 64'(runs), 64'd1);

        // 3: gapped input
        drive_samples(0, 0, 8, 1'b1, 1'b0);
        check_latency("t3_latency");
        wait_drain("t3_drain");

        // 4: extremes at natural index 3
        drive_samples(0, 0, 8, 1'b0, 1'b1);
        wait_drain("t4_drain");

        // 5: reset mid-frame, then during readout
        drive_samples(0, 0, 5, 1'b0, 1'b0);
        apply_reset("t5_reset_partial");
        drive_samples(200, 0, 8, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        apply_reset("t5_reset_readout");
        vcnt = 0;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_stale", 64'(vcnt), 64'd0);
        drive_samples(300, 0, 8, 1'b0, 1'b0);
        wait_drain("t5_drain");

        // 6: idle with 7 of 8 inputs
        drive_samples(0, 0, 7, 1'b0, 1'b0);
        vcnt = 0;
        repeat (50) @(posedge clk);
        #1;
        check("t6_idle_no_valid", 64'(vcnt), 64'd0);
        drive_samples(0, 7, 1, 1'b0, 1'b0);
        check_latency("t6_latency");
        wait_drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
